// File: rtl/instr_mem_ctrl.sv
// IF-stage instruction memory with a byte-stream program loader and registered word fetch.
// Optional debug read port enabled by defining INSTR_MEM_DEBUG_RD_EN.
module instr_mem_ctrl #(
    parameter int unsigned B  = 32,
    parameter int unsigned W  = 8,
    parameter int unsigned PC = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load_start,
    input  logic          i_load_valid,
    input  logic [7:0]    i_load_byte,
    input  logic          i_load_done,
    input  logic          i_fetch_en,
    input  logic          i_flush,
    input  logic [PC-1:0] i_pc,
`ifdef INSTR_MEM_DEBUG_RD_EN
    input  logic [W-1:0]  i_dbg_addr,
    output logic [B-1:0]  o_dbg_data,
`endif
    output logic [B-1:0]  o_instr,
    output logic          o_instr_valid,
    output logic          o_misaligned,
    output logic [W:0]    o_loaded_words,
    output logic          o_load_full,
    output logic          o_run
);

    localparam int unsigned NB    = B / 8;
    localparam int unsigned LB    = $clog2(NB);
    localparam int unsigned DEPTH = 2 ** W;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_nx;
    logic [W:0]      wr_ptr, wr_ptr_nx;
    logic [LB-1:0]   byte_cnt, byte_cnt_nx;
    logic [B-1:0]    asm_q, asm_nx;
    logic [B-1:0]    instr_nx;
    logic            valid_nx, mis_nx;

    logic [B-1:0]    mem [DEPTH];
    logic            wr_en;
    logic [W-1:0]    wr_addr;
    logic [B-1:0]    wr_data;

    logic [PC-1:0]   idx;
    logic [B-1:0]    rd_data;

    assign idx            = i_pc >> LB;
    assign rd_data        = mem[idx[W-1:0]];
    assign o_loaded_words = wr_ptr;
    // wr_ptr never exceeds DEPTH, so its top bit is exactly the full flag
    assign o_load_full    = wr_ptr[W];
    assign o_run          = (state == RUN);

    // Next-state, loader datapath and fetch result
    always_comb begin
        state_nx    = state;
        wr_ptr_nx   = wr_ptr;
        byte_cnt_nx = byte_cnt;
        asm_nx      = asm_q;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr[W-1:0];
        wr_data     = asm_q;
        instr_nx    = o_instr;
        valid_nx    = o_instr_valid;
        mis_nx      = o_misaligned;

        case (state)
            LOAD: begin
                instr_nx = '0;
                valid_nx = 1'b0;
                if (i_load_valid && !wr_ptr[W]) begin
                    asm_nx[{byte_cnt, 3'b000} +: 8] = i_load_byte;
                    if (byte_cnt == LB'(NB - 1)) begin
                        wr_en       = 1'b1;
                        wr_data     = asm_nx;
                        wr_ptr_nx   = wr_ptr + 1'b1;
                        byte_cnt_nx = '0;
                        asm_nx      = '0;
                    end else begin
                        byte_cnt_nx = byte_cnt + 1'b1;
                    end
                end
                // A nonzero lane count means no word was written above, so wr_ptr is still current
                if (i_load_done) begin
                    if (byte_cnt_nx != '0 && !wr_ptr[W]) begin
                        wr_en     = 1'b1;
                        wr_data   = asm_nx;
                        wr_ptr_nx = wr_ptr + 1'b1;
                    end
                    byte_cnt_nx = '0;
                    asm_nx      = '0;
                    state_nx    = RUN;
                end
            end
            RUN: begin
                if (i_load_start) begin
                    state_nx    = LOAD;
                    wr_ptr_nx   = '0;
                    byte_cnt_nx = '0;
                    asm_nx      = '0;
                    instr_nx    = '0;
                    valid_nx    = 1'b0;
                end else if (i_flush) begin
                    instr_nx = '0;
                    valid_nx = 1'b0;
                end else if (i_fetch_en) begin
                    if (i_pc[LB-1:0] != '0) begin
                        instr_nx = '0;
                        valid_nx = 1'b0;
                        mis_nx   = 1'b1;
                    end else if (idx >= PC'(wr_ptr)) begin
                        instr_nx = '0;
                        valid_nx = 1'b0;
                        mis_nx   = 1'b0;
                    end else begin
                        instr_nx = rd_data;
                        valid_nx = 1'b1;
                        mis_nx   = 1'b0;
                    end
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= LOAD;
            wr_ptr        <= '0;
            byte_cnt      <= '0;
            asm_q         <= '0;
            o_instr       <= '0;
            o_instr_valid <= 1'b0;
            o_misaligned  <= 1'b0;
        end else begin
            state         <= state_nx;
            wr_ptr        <= wr_ptr_nx;
            byte_cnt      <= byte_cnt_nx;
            asm_q         <= asm_nx;
            o_instr       <= instr_nx;
            o_instr_valid <= valid_nx;
            o_misaligned  <= mis_nx;
        end
    end

    // Array contents survive reset; reachability is governed by wr_ptr
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef INSTR_MEM_DEBUG_RD_EN
    assign o_dbg_data = mem[i_dbg_addr];
`else
    // Single read port: only the fetch path reads the array
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl (B=32, W=2): loader, fetch, stall/flush, full and reset cases.
module tb_instr_mem_ctrl;

    localparam int unsigned B  = 32;
    localparam int unsigned W  = 2;
    localparam int unsigned PC = 32;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_load_start = 1'b0;
    logic          i_load_valid = 1'b0;
    logic [7:0]    i_load_byte = '0;
    logic          i_load_done = 1'b0;
    logic          i_fetch_en = 1'b0;
    logic          i_flush = 1'b0;
    logic [PC-1:0] i_pc = '0;
    logic [B-1:0]  o_instr;
    logic          o_instr_valid;
    logic          o_misaligned;
    logic [W:0]    o_loaded_words;
    logic          o_load_full;
    logic          o_run;

    instr_mem_ctrl #(.B(B), .W(W), .PC(PC)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load_start  (i_load_start),
        .i_load_valid  (i_load_valid),
        .i_load_byte   (i_load_byte),
        .i_load_done   (i_load_done),
        .i_fetch_en    (i_fetch_en),
        .i_flush       (i_flush),
        .i_pc          (i_pc),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .o_misaligned  (o_misaligned),
        .o_loaded_words(o_loaded_words),
        .o_load_full   (o_load_full),
        .o_run         (o_run)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    logic [31:0] m_mem [4];
    int          m_words = 0;
    int          m_lane = 0;
    logic [31:0] m_asm = '0;
    logic [31:0] m_instr = '0;
    logic        m_valid = 1'b0;
    logic        m_mis = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_reset();
        m_words = 0;
        m_lane  = 0;
        m_asm   = '0;
        m_instr = '0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic done);
        i_load_valid = 1'b1;
        i_load_byte  = b;
        i_load_done  = done;
        step();
        i_load_valid = 1'b0;
        i_load_done  = 1'b0;
        if (m_words < 4) begin
            m_asm[m_lane*8 +: 8] = b;
            m_lane++;
            if (m_lane == 4) begin
                m_mem[m_words] = m_asm;
                m_words++;
                m_lane = 0;
                m_asm  = '0;
            end
        end
        if (done) begin
            if (m_lane != 0 && m_words < 4) begin
                m_mem[m_words] = m_asm;
                m_words++;
            end
            m_lane = 0;
            m_asm  = '0;
        end
    endtask

    task automatic send_done();
        i_load_done = 1'b1;
        step();
        i_load_done = 1'b0;
        if (m_lane != 0 && m_words < 4) begin
            m_mem[m_words] = m_asm;
            m_words++;
        end
        m_lane = 0;
        m_asm  = '0;
    endtask

    task automatic load_start();
        i_load_start = 1'b1;
        step();
        i_load_start = 1'b0;
        m_words = 0;
        m_instr = '0;
        m_valid = 1'b0;
    endtask

    // Predict, drive one fetch cycle, then compare the popped expectation
    task automatic fetch(input string tag, input logic [31:0] pc, input logic flush);
        exp_t e;
        if (flush) begin
            m_instr = '0;
            m_valid = 1'b0;
        end else if (pc[1:0] != 2'b00) begin
            m_instr = '0;
            m_valid = 1'b0;
            m_mis   = 1'b1;
        end else if ((pc >> 2) >= 32'(m_words)) begin
            m_instr = '0;
            m_valid = 1'b0;
            m_mis   = 1'b0;
        end else begin
            m_instr = m_mem[pc[3:2]];
            m_valid = 1'b1;
            m_mis   = 1'b0;
        end
        e.instr = m_instr;
        e.valid = m_valid;
        e.mis   = m_mis;
        sb.push_back(e);
        i_pc       = pc;
        i_fetch_en = 1'b1;
        i_flush    = flush;
        step();
        i_fetch_en = 1'b0;
        i_flush    = 1'b0;
        e = sb.pop_front();
        check_val({tag, "_instr"}, 64'(o_instr), 64'(e.instr));
        check_val({tag, "_valid"}, 64'(o_instr_valid), 64'(e.valid));
        check_val({tag, "_mis"}, 64'(o_misaligned), 64'(e.mis));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        step();
        check_val("rst_run", 64'(o_run), 64'(0));
        check_val("rst_words", 64'(o_loaded_words), 64'(0));
        check_val("rst_full", 64'(o_load_full), 64'(0));
        check_val("rst_valid", 64'(o_instr_valid), 64'(0));
        check_val("rst_instr", 64'(o_instr), 64'(0));
        i_reset = 1'b0;
        step();

        // Fetch attempts during LOAD are ignored
        i_fetch_en = 1'b1;
        i_pc       = '0;
        step();
        i_fetch_en = 1'b0;
        check_val("load_fetch_valid", 64'(o_instr_valid), 64'(0));

        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0);
        send_done();
        check_val("t1_words", 64'(o_loaded_words), 64'(2));
        check_val("t1_run", 64'(o_run), 64'(1));
        fetch("t1_pc4", 32'h4, 1'b0);
        check_val("t1_const", 64'(o_instr), 64'h0010_0093);
        fetch("t1_pc0", 32'h0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_instr", 64'(o_instr), 64'(m_instr));
            check_val("stall_valid", 64'(o_instr_valid), 64'(m_valid));
        end
        fetch("flush", 32'h0, 1'b1);
        fetch("mis_pc2", 32'h2, 1'b0);
        fetch("mis_pc0", 32'h0, 1'b0);

        load_start();
        check_val("ls_run", 64'(o_run), 64'(0));
        check_val("ls_words", 64'(o_loaded_words), 64'(0));
        check_val("ls_valid", 64'(o_instr_valid), 64'(0));
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'h11 + i), (i == 4));
        end
        check_val("t2_words", 64'(o_loaded_words), 64'(2));
        check_val("t2_run", 64'(o_run), 64'(1));
        fetch("t2_pc4", 32'h4, 1'b0);
        check_val("t2_const", 64'(o_instr), 64'h0000_0015);
        fetch("t2_pc8", 32'h8, 1'b0);

        load_start();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h20 + i), 1'b0);
        end
        check_val("full_flag", 64'(o_load_full), 64'(1));
        check_val("full_words", 64'(o_loaded_words), 64'(4));
        for (int i = 16; i < 20; i++) begin
            send_byte(8'(8'h20 + i), 1'b0);
        end
        send_done();
        check_val("full_words2", 64'(o_loaded_words), 64'(4));
        fetch("full_pc0", 32'h0, 1'b0);
        check_val("full_mem0", 64'(o_instr), 64'h2322_2120);
        fetch("full_pc12", 32'hC, 1'b0);
        fetch("full_pc16", 32'h10, 1'b0);
        fetch("full_pc_hi", 32'h100, 1'b0);

        // Asynchronous reset between clock edges while in RUN
        i_reset = 1'b1;
        #2;
        check_val("arst_run", 64'(o_run), 64'(0));
        check_val("arst_words", 64'(o_loaded_words), 64'(0));
        check_val("arst_full", 64'(o_load_full), 64'(0));
        i_reset = 1'b0;
        model_reset();
        send_byte(8'hEE, 1'b0);
        send_byte(8'hEF, 1'b0);
        i_reset = 1'b1;
        #2;
        i_reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'h01 + i), 1'b0);
        end
        send_done();
        check_val("rl_words", 64'(o_loaded_words), 64'(1));
        fetch("rl_pc0", 32'h0, 1'b0);
        check_val("rl_const", 64'(o_instr), 64'h0403_0201);
        fetch("rl_pc4", 32'h4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
